// File: rtl/mem_block_responder_if.sv
// mem_block_responder_if
//   Block-level bus between the direct-mapped cache and its memory responder.
//   master : cache side, drives the request (mem_read/mem_write, mem_addr,
//            mem_wdata) and observes the response.
//   slave  : memory side, returns mem_rdata/mem_ready and the access
//            statistics rd_count/wr_count.
interface mem_block_responder_if;
   logic         mem_read;
   logic         mem_write;
   logic [27:0]  mem_addr;
   logic [127:0] mem_wdata;
   logic [127:0] mem_rdata;
   logic         mem_ready;
   logic [15:0]  rd_count;
   logic [15:0]  wr_count;

   modport master (
      output mem_read, mem_write, mem_addr, mem_wdata,
      input  mem_rdata, mem_ready, rd_count, wr_count
   );

   modport slave (
      input  mem_read, mem_write, mem_addr, mem_wdata,
      output mem_rdata, mem_ready, rd_count, wr_count
   );
endinterface

// File: rtl/mem_block_responder.sv
// mem_block_responder
//   Main-memory model/controller under the direct-mapped cache. A request
//   (mem_read | mem_write, held as a level) must be seen for LATENCY
//   consecutive cycles. The access is performed at the edge that ends the
//   last counted cycle, and a one-cycle mem_ready pulse follows. Address,
//   data and request type are taken at that access edge, so the requester
//   may settle its address after raising the request.
//
// Parameters
//   ADDR_W  : low mem_addr bits that index the array (upper bits alias)
//   LATENCY : request cycles per access, 1..255
//   CNT_W   : latency counter width, must hold LATENCY
//
// Ports
//   clk          : clock, all state on the rising edge
//   proc_reset_n : asynchronous active-low reset
//   bus          : slave side of mem_block_responder_if
//                  mem_read/mem_write/mem_addr/mem_wdata in,
//                  mem_rdata/mem_ready/rd_count/wr_count out
//
// Build option
//   MEM_BLOCK_RESPONDER_STATS_EN : when defined, rd_count/wr_count count
//   performed accesses (saturating at 16'hFFFF). Otherwise both read as 0.
module mem_block_responder #(
   parameter int ADDR_W  = 8,
   parameter int LATENCY = 4,
   parameter int CNT_W   = 8
) (
   input logic                    clk,
   input logic                    proc_reset_n,
   mem_block_responder_if.slave   bus
);

   typedef enum logic [1:0] {IDLE, WAIT, READY} state_t;

   state_t             state, state_nxt;
   logic [CNT_W-1:0]   cnt, cnt_nxt;
   logic               req;
   logic               last;
   logic               do_access;
   logic               do_write;
   logic               do_read;
   logic [ADDR_W-1:0]  idx;
   logic [127:0]       mem [2**ADDR_W];
   logic [127:0]       rdata_q;
   logic               ready_q;
   logic               unused_addr;

   assign req         = bus.mem_read | bus.mem_write;
   assign idx         = bus.mem_addr[ADDR_W-1:0];
   assign unused_addr = ^bus.mem_addr[27:ADDR_W];

   // cnt is 0 in IDLE, so in IDLE this is only true for LATENCY==1; that
   // lets IDLE and WAIT share the same completion test.
   assign last = (cnt + CNT_W'(1)) == CNT_W'(LATENCY);

   // ---------------- state register ----------------
   always_ff @(posedge clk or negedge proc_reset_n) begin
      if (!proc_reset_n) state <= IDLE;
      else               state <= state_nxt;
   end

   // ---------------- next-state logic ----------------
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (req) state_nxt = last ? READY : WAIT;
         WAIT:    if (!req)     state_nxt = IDLE;
                  else if (last) state_nxt = READY;
         READY:   state_nxt = IDLE;   // requests in READY are not counted
         default: state_nxt = IDLE;
      endcase
   end

   // ---------------- output / datapath control ----------------
   always_comb begin
      do_access = (state != READY) && (state_nxt == READY);
      // both asserted is a write; mem_rdata is left alone
      do_write  = do_access & bus.mem_write;
      do_read   = do_access & bus.mem_read & ~bus.mem_write;
      cnt_nxt   = (state_nxt == WAIT) ? cnt + CNT_W'(1) : '0;
   end

   always_ff @(posedge clk or negedge proc_reset_n) begin
      if (!proc_reset_n) begin
         cnt     <= '0;
         ready_q <= 1'b0;
         rdata_q <= '0;
      end else begin
         cnt     <= cnt_nxt;
         ready_q <= do_access;
         if (do_read) rdata_q <= mem[idx];
      end
   end

   // Array is not reset; the reset gate keeps an edge that lands while
   // reset is held from writing.
   always_ff @(posedge clk) begin
      if (do_write && proc_reset_n) mem[idx] <= bus.mem_wdata;
   end

   assign bus.mem_rdata = rdata_q;
   assign bus.mem_ready = ready_q;

`ifdef MEM_BLOCK_RESPONDER_STATS_EN
   logic [15:0] rd_cnt_q, wr_cnt_q;

   always_ff @(posedge clk or negedge proc_reset_n) begin
      if (!proc_reset_n) begin
         rd_cnt_q <= '0;
         wr_cnt_q <= '0;
      end else begin
         if (do_read  && rd_cnt_q != 16'hFFFF) rd_cnt_q <= rd_cnt_q + 16'd1;
         if (do_write && wr_cnt_q != 16'hFFFF) wr_cnt_q <= wr_cnt_q + 16'd1;
      end
   end

   assign bus.rd_count = rd_cnt_q;
   assign bus.wr_count = wr_cnt_q;
`else
   assign bus.rd_count = '0;
   assign bus.wr_count = '0;
`endif

endmodule

// File: tb/tb_mem_block_responder.sv
module tb_mem_block_responder;
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   mem_block_responder_if bus4 ();
   mem_block_responder_if bus1 ();

   mem_block_responder #(.ADDR_W(8), .LATENCY(4), .CNT_W(8)) dut4 (
      .clk(clk), .proc_reset_n(rst_n), .bus(bus4));
   mem_block_responder #(.ADDR_W(8), .LATENCY(1), .CNT_W(8)) dut1 (
      .clk(clk), .proc_reset_n(rst_n), .bus(bus1));

   typedef struct {
      bit           rd;
      bit           wr;
      logic [27:0]  a0;        // address in cycle 0
      logic [27:0]  a;         // address from cycle 1 on
      logic [127:0] wd;
      logic [127:0] exp_rdata;
   } vec_t;

   typedef struct {
      logic [127:0] rdata;
      int           lat;
   } exp_t;

   exp_t sbq[$];
   vec_t vt[10];
   int   nvec = 0, nerr = 0;
   int   cyc = 0;
   int   rdy_cyc;
   int   rdy_at[10];

   always @(posedge clk) cyc++;

   task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h", nm, got, exp);
      end
   endtask

   task automatic drive(input int sel, input bit rd, input bit wr,
                        input logic [27:0] a, input logic [127:0] wd);
      if (sel == 1) begin
         bus1.mem_read = rd; bus1.mem_write = wr; bus1.mem_addr = a; bus1.mem_wdata = wd;
      end else begin
         bus4.mem_read = rd; bus4.mem_write = wr; bus4.mem_addr = a; bus4.mem_wdata = wd;
      end
   endtask

   function automatic logic rdy(input int sel);
      return (sel == 1) ? bus1.mem_ready : bus4.mem_ready;
   endfunction

   function automatic logic [127:0] rdat(input int sel);
      return (sel == 1) ? bus1.mem_rdata : bus4.mem_rdata;
   endfunction

   // One request: cycle 0 begins right after the next rising edge; the
   // request is held until mem_ready is seen and dropped in that cycle.
   task automatic run(input string nm, input int sel, input bit rd, input bit wr,
                      input logic [27:0] a0, input logic [27:0] a,
                      input logic [127:0] wd, input logic [127:0] exp_rdata,
                      input int lat);
      exp_t e;
      int   got;
      @(posedge clk); #1;
      chk({nm, " ready_low_before"}, rdy(sel), 1'b0);
      drive(sel, rd, wr, a0, wd);
      e.rdata = exp_rdata;
      e.lat   = lat;
      sbq.push_back(e);
      got = 0;
      for (int k = 1; k <= lat + 4; k++) begin
         @(posedge clk); #1;
         if (k == 1) drive(sel, rd, wr, a, wd);
         if (rdy(sel)) begin
            got = k;
            break;
         end
      end
      rdy_cyc = cyc;
      drive(sel, 1'b0, 1'b0, a, wd);
      e = sbq.pop_front();
      chk({nm, " latency"}, got, e.lat);
      chk({nm, " rdata"}, rdat(sel), e.rdata);
   endtask

   initial begin
      logic [127:0] d_a5, d_12, d_0f, d_cc, d_77, d_40, d_41, d_42, d_11, d_99;
      int seen;
      d_a5 = {16{8'hA5}};
      d_12 = {4{32'h1200_00D1}};
      d_0f = {16{8'h0F}};
      d_cc = {16{8'hCC}};
      d_77 = {16{8'h77}};
      d_40 = {8{16'h4040}};
      d_41 = {8{16'h4141}};
      d_42 = {8{16'h4242}};
      d_11 = {16{8'h11}};
      d_99 = {16{8'h99}};

      //        rd wr  a0            a             wd    exp_rdata
      vt[0] = '{0, 1, 28'h0000005, 28'h0000005, d_a5, '0  };
      vt[1] = '{1, 0, 28'h0000005, 28'h0000005, '0,   d_a5};  // back-to-back
      vt[2] = '{0, 1, 28'h0000012, 28'h0000012, d_12, d_a5};
      vt[3] = '{0, 1, 28'h0000000, 28'h0000000, d_0f, d_a5};
      vt[4] = '{1, 0, 28'h0000000, 28'h0000012, '0,   d_12};  // addr settles late
      vt[5] = '{0, 1, 28'h0000100, 28'h0000100, d_cc, d_12};  // aliases entry 0
      vt[6] = '{1, 0, 28'h0000000, 28'h0000000, '0,   d_cc};
      vt[7] = '{1, 1, 28'h0000033, 28'h0000033, d_77, d_cc};  // both -> write
      vt[8] = '{1, 0, 28'h0000033, 28'h0000033, '0,   d_77};
      vt[9] = '{1, 0, 28'h0000133, 28'h0000133, '0,   d_77};

      rst_n = 1'b0;
      drive(4, 0, 0, '0, '0);
      drive(1, 0, 0, '0, '0);
      repeat (3) @(posedge clk);
      #1;
      chk("reset ready4", bus4.mem_ready, 1'b0);
      chk("reset rdata4", bus4.mem_rdata, '0);
      chk("reset rd_count", bus4.rd_count, '0);
      chk("reset wr_count", bus4.wr_count, '0);
      chk("reset ready1", bus1.mem_ready, 1'b0);
      chk("reset rdata1", bus1.mem_rdata, '0);
      rst_n = 1'b1;

      for (int i = 0; i < 10; i++) begin
         run($sformatf("vec%0d", i), 4, vt[i].rd, vt[i].wr, vt[i].a0, vt[i].a,
             vt[i].wd, vt[i].exp_rdata, 4);
         rdy_at[i] = rdy_cyc;
      end
      chk("back_to_back gap", rdy_at[1] - rdy_at[0], 5);

      // read data held after the request drops
      run("hold_rd", 4, 1, 0, 28'h5, 28'h5, '0, d_a5, 4);
      repeat (3) @(posedge clk);
      #1;
      chk("hold rdata", bus4.mem_rdata, d_a5);

      // abort after two request cycles
      @(posedge clk); #1;
      drive(4, 1, 0, 28'h12, '0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      drive(4, 0, 0, 28'h12, '0);
      seen = 0;
      for (int k = 0; k < 6; k++) begin
         @(posedge clk); #1;
         if (bus4.mem_ready) seen++;
      end
      chk("abort no_ready", seen, 0);
      chk("abort rdata", bus4.mem_rdata, d_a5);
      run("after_abort", 4, 1, 0, 28'h12, 28'h12, '0, d_12, 4);

      // reset in cycle 2 of a write: no completion, old entry kept
      @(posedge clk); #1;
      drive(4, 0, 1, 28'h5, {16{8'hDE}});
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      chk("rst_wait ready", bus4.mem_ready, 1'b0);
      chk("rst_wait rdata", bus4.mem_rdata, '0);
      @(posedge clk); #1;
      chk("rst_wait ready2", bus4.mem_ready, 1'b0);
      drive(4, 0, 0, 28'h5, '0);
      rst_n = 1'b1;
      run("rst_keep", 4, 1, 0, 28'h5, 28'h5, '0, d_a5, 4);

      run("st_w40", 4, 0, 1, 28'h40, 28'h40, d_40, d_a5, 4);
      run("st_w41", 4, 0, 1, 28'h41, 28'h41, d_41, d_a5, 4);
      run("st_w42", 4, 0, 1, 28'h42, 28'h42, d_42, d_a5, 4);
      run("st_r41", 4, 1, 0, 28'h41, 28'h41, '0, d_41, 4);
`ifdef MEM_BLOCK_RESPONDER_STATS_EN
      chk("stats wr_count", bus4.wr_count, 16'd3);
      chk("stats rd_count", bus4.rd_count, 16'd2);
`else
      chk("stats wr_count", bus4.wr_count, 16'd0);
      chk("stats rd_count", bus4.rd_count, 16'd0);
`endif

      // LATENCY=1 instance
      run("l1_w7", 1, 0, 1, 28'h7, 28'h7, d_11, '0, 1);
      run("l1_r7", 1, 1, 0, 28'h7, 28'h7, '0, d_11, 1);
      run("l1_both7", 1, 1, 1, 28'h7, 28'h7, d_99, d_11, 1);
      run("l1_r7b", 1, 1, 0, 28'h7, 28'h7, '0, d_99, 1);
`ifdef MEM_BLOCK_RESPONDER_STATS_EN
      chk("l1 wr_count", bus1.wr_count, 16'd2);
      chk("l1 rd_count", bus1.rd_count, 16'd2);
`else
      chk("l1 wr_count", bus1.wr_count, 16'd0);
      chk("l1 rd_count", bus1.rd_count, 16'd0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
